vx_tensor_imma_group: RTL
=========================

# vx_tensor_imma_group

Parametrised integer matrix-multiply-accumulate threadgroup: computes D = A×B + C for an M×K by K×N fragment pair, wrapping at 32 bits. It uses LANES dot-product lanes time-multiplexed over STEPS = M·N/LANES issue cycles. It sits in the tensor core beside the FP threadgroups, fed by the tensor DPU wrapper. Compared with the fixed 2×4×2 FP group, it adds configurable M/N/K/lanes/latency, signed/unsigned mode and tag passthrough.

## Interface
- M, 2, fragment rows
- N, 4, fragment columns
- K, 2, reduction depth
- DW, 8, A/B element width (bits)
- LANES, 4, dot-product lanes; must divide M·N (elaboration `$error` otherwise)
- LATENCY, 2, dot-product pipeline stages (≥1)
- IBUF_DEPTH, 2, input buffer entries (≥2)
- TAGW, 4, tag width
- clk  in  1  clock
- reset  in  1  async active-high reset
- valid_in  in  1  fragment offered
- ready_in  out  1  input buffer not full; low while reset asserted
- A_frag  in  M·K·DW  [M][K] elements, row-major
- B_frag  in  K·N·DW  [K][N] elements
- C_frag  in  M·N·32  [M][N] accumulators
- signed_in  in  1  1: A/B two's-complement; 0: unsigned
- tag_in  in  TAGW  opaque tag (warp id)
- valid_out  out  1  D_frag/tag_out valid
- ready_out  in  1  consumer accepts
- D_frag  out  M·N·32  [M][N] results
- tag_out  out  TAGW  tag of the fragment in D_frag

## Operation
- Accept: valid_in && ready_in pushes {A, B, C, signed_in, tag_in} into the IBUF_DEPTH FIFO. FIFO output is registered, so an entry becomes visible the cycle after the push.
- Global advance: pipe_en = !valid_out || ready_out. When low, the issue stage, pipeline and collector all hold.
- Issue: on pipe_en && FIFO non-empty, issue step s (counter 0..STEPS-1).
  - Lane l computes element j = s·LANES + l, with row = j / N and col = j % N.
  - Lane result: C[row][col] + Σk A[row][k]·B[k][col].
  - The counter wraps to 0 after step STEPS-1. That same issue pops the FIFO.
- Arithmetic:
  - Operands are sign- or zero-extended per the entry's signed flag.
  - Products are full 2·DW bits.
  - The sum is truncated mod 2^32; no saturation and no overflow flag.
- Pipeline: LATENCY stages carry {valid, step, last, tag, LANES×32 results}.
- Collector:
  - A non-last step's results are written into the D staging register at its element positions.
  - The last step's results merge with staging into the output register; this sets valid_out and loads tag_out.
- Output: valid_out && ready_out clears valid_out, unless a last step arrives in the same cycle. In that case the new result loads and valid_out stays 1.
- D_frag and tag_out are held stable while valid_out && !ready_out.
- Fragments complete strictly in acceptance order.
- Async reset clears the FIFO, step counter, pipeline valids, staging, valid_out, D_frag (0) and tag_out (0) immediately, with no clock edge needed. In-flight fragments are discarded.

## Timing
- Latency: with ready_out held 1, valid_out rises STEPS+LATENCY+1 cycles after the accepting edge. For defaults that is 5.
- Throughput: one fragment per STEPS cycles, sustained when IBUF_DEPTH ≥ 2.
- ready_in is a function of FIFO fullness only, never of valid_in. Push and pop on a full FIFO in the same cycle is not allowed, because ready_in = 0.
- Simultaneous push/pop on a non-full FIFO leaves occupancy unchanged.
- First cycle after reset deassertion: ready_in = 1, valid_out = 0.

## Test plan
- Defaults, signed, A=[[1,2],[3,4]], B=[[1,2,3,4],[5,6,7,8]], C=0, tag=3 -> D=[[11,14,17,20],[23,30,37,44]], tag_out=3, valid_out exactly 5 cycles after accept.
- A all 8'hFF, B all 8'h02, C=0 -> signed: every D = 32'hFFFFFFFC; unsigned: every D = 1020.
- 4 back-to-back fragments (tags 0..3), ready_out=1 -> four outputs spaced 2 cycles apart, tags 0,1,2,3, each D matching the reference model.
- Hold ready_out=0 for 12 cycles during a stream -> the following must all hold:
  - valid_out, D_frag and tag_out are stable.
  - ready_in drops once the FIFO is full.
  - No fragment is lost or duplicated after release.
- C=32'h7FFFFFFF with A·B=1 -> D=32'h80000000 (wrap). Repeat with LANES=8 (STEPS=1): latency = LATENCY+2 = 4.
- Assert reset asynchronously mid-fragment -> valid_out, D_frag and tag_out go 0 before the next edge. After release, no stale output appears and the next fragment computes correctly.

Source files
------------

// File: rtl/vx_tensor_imma_group.sv
// Integer MMA threadgroup: D = A*B + C (mod 2^32) for an MxK by KxN fragment pair,
// computed by LANES dot-product lanes time-multiplexed over M*N/LANES issue steps.
module vx_tensor_imma_group #(
  parameter int M          = 2,
  parameter int N          = 4,
  parameter int K          = 2,
  parameter int DW         = 8,
  parameter int LANES      = 4,
  parameter int LATENCY    = 2,
  parameter int IBUF_DEPTH = 2,
  parameter int TAGW       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  output logic                ready_in,
  input  logic [M*K*DW-1:0]   A_frag,
  input  logic [K*N*DW-1:0]   B_frag,
  input  logic [M*N*32-1:0]   C_frag,
  input  logic                signed_in,
  input  logic [TAGW-1:0]     tag_in,
  output logic                valid_out,
  input  logic                ready_out,
  output logic [M*N*32-1:0]   D_frag,
  output logic [TAGW-1:0]     tag_out
);
  localparam int STEPS = M * N / LANES;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PW    = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int AW    = M * K * DW;
  localparam int BW    = K * N * DW;
  localparam int CW    = M * N * 32;
  localparam int EW    = AW + BW + CW + 1 + TAGW;

  if ((M * N) % LANES != 0) begin : g_lanes_chk
    $error("vx_tensor_imma_group: LANES must divide M*N");
  end

  logic [EW-1:0]   mem [IBUF_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            push_q, push, pop, avail, pipe_en, issue, last;
  logic [SW-1:0]   step;
  logic [EW-1:0]   head;
  logic [AW-1:0]   head_a;
  logic [BW-1:0]   head_b;
  logic [CW-1:0]   head_c;
  logic            head_sgn;
  logic [TAGW-1:0] head_tag;

  assign ready_in = !reset && (count != (PW+1)'(IBUF_DEPTH));
  assign push     = valid_in && ready_in;
  // An entry pushed on the previous edge is not yet visible to the issue stage.
  assign avail    = count > {{PW{1'b0}}, push_q};
  assign pipe_en  = !valid_out || ready_out;
  assign issue    = pipe_en && avail;
  assign last     = (step == SW'(STEPS - 1));
  assign pop      = issue && last;

  assign head     = mem[rd_ptr];
  assign head_a   = head[AW-1:0];
  assign head_b   = head[AW +: BW];
  assign head_c   = head[AW+BW +: CW];
  assign head_sgn = head[AW+BW+CW];
  assign head_tag = head[EW-1 -: TAGW];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {tag_in, signed_in, C_frag, B_frag, A_frag};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      push_q <= 1'b0;
      step   <= '0;
    end else begin
      push_q <= push;
      if (push) wr_ptr <= (wr_ptr == PW'(IBUF_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(IBUF_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (issue) step <= last ? '0 : step + 1'b1;
    end
  end

  logic [LANES*32-1:0] lane_res;
  logic signed [DW:0]  opa, opb;
  logic signed [63:0]  prod;
  logic [31:0]         acc;
  int                  j, row, col;

  always_comb begin
    lane_res = '0;
    opa = '0;
    opb = '0;
    prod = '0;
    acc = '0;
    j = 0;
    row = 0;
    col = 0;
    for (int l = 0; l < LANES; l++) begin
      j   = int'(step) * LANES + l;
      row = j / N;
      col = j % N;
      acc = head_c[(row*N + col)*32 +: 32];
      for (int k = 0; k < K; k++) begin
        opa  = {head_sgn & head_a[(row*K + k)*DW + DW - 1], head_a[(row*K + k)*DW +: DW]};
        opb  = {head_sgn & head_b[(k*N + col)*DW + DW - 1], head_b[(k*N + col)*DW +: DW]};
        prod = 64'(opa) * 64'(opb);
        acc  = acc + prod[31:0];
      end
      lane_res[l*32 +: 32] = acc;
    end
  end

  logic [LATENCY-1:0]  p_valid, p_last;
  logic [SW-1:0]       p_step [LATENCY];
  logic [TAGW-1:0]     p_tag  [LATENCY];
  logic [LANES*32-1:0] p_res  [LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_valid <= '0;
      p_last  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        p_step[i] <= '0;
        p_tag[i]  <= '0;
        p_res[i]  <= '0;
      end
    end else if (pipe_en) begin
      p_valid[0] <= issue;
      p_last[0]  <= last;
      p_step[0]  <= step;
      p_tag[0]   <= head_tag;
      p_res[0]   <= lane_res;
      for (int i = 1; i < LATENCY; i++) begin
        p_valid[i] <= p_valid[i-1];
        p_last[i]  <= p_last[i-1];
        p_step[i]  <= p_step[i-1];
        p_tag[i]   <= p_tag[i-1];
        p_res[i]   <= p_res[i-1];
      end
    end
  end

  logic [CW-1:0] staging, merged;

  always_comb begin
    merged = staging;
    for (int l = 0; l < LANES; l++)
      merged[(int'(p_step[LATENCY-1])*LANES + l)*32 +: 32] = p_res[LATENCY-1][l*32 +: 32];
  end

  // Every element position is rewritten each fragment, so staging never needs clearing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging   <= '0;
      D_frag    <= '0;
      tag_out   <= '0;
      valid_out <= 1'b0;
    end else begin
      if (ready_out) valid_out <= 1'b0;
      if (pipe_en && p_valid[LATENCY-1]) begin
        if (p_last[LATENCY-1]) begin
          D_frag    <= merged;
          tag_out   <= p_tag[LATENCY-1];
          valid_out <= 1'b1;
        end else begin
          staging <= merged;
        end
      end
    end
  end
endmodule
